// File: rtl/counter_pkg.sv
// Shared definitions for the up/down/set counter family: resolved op-codes,
// default width and the per-edge priority resolver.
package counter_pkg;

  localparam int CNT_W_DEFAULT = 8;

  // Operation chosen for one clock edge after priority resolution.
  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_RESET = 3'd1,
    OP_CLR   = 3'd2,
    OP_LOAD  = 3'd3,
    OP_INC   = 3'd4,
    OP_DEC   = 3'd5
  } op_e;

  // rst > clr > set > (up && down -> hold) > up > down > hold.
  function automatic op_e resolve_op(
    input logic rst,
    input logic clr,
    input logic set,
    input logic up,
    input logic down
  );
    if (rst)              return OP_RESET;
    else if (clr)         return OP_CLR;
    else if (set)         return OP_LOAD;
    else if (up && down)  return OP_HOLD;
    else if (up)          return OP_INC;
    else if (down)        return OP_DEC;
    else                  return OP_HOLD;
  endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-value datapath for up_down_set_counter.
// UDS_COUNTER_SATURATE_EN selects clamping at the ends plus a blocked flag.
module counter_next
  import counter_pkg::*;
#(
  parameter int              WIDTH     = CNT_W_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_count,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_next
`ifdef UDS_COUNTER_SATURATE_EN
  ,
  output logic             o_blocked
`endif
);

  logic w_is_max;
  logic w_is_zero;

  assign w_is_max  = (i_count == {WIDTH{1'b1}});
  assign w_is_zero = (i_count == '0);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    o_next = i_count;
`ifdef UDS_COUNTER_SATURATE_EN
    o_blocked = 1'b0;
`endif
    unique case (i_op)
      OP_RESET: o_next = RESET_VAL;
      OP_CLR:   o_next = '0;
      OP_LOAD:  o_next = i_load_val;
      OP_INC: begin
`ifdef UDS_COUNTER_SATURATE_EN
        if (w_is_max) o_blocked = 1'b1;
        else          o_next    = i_count + WIDTH'(1);
`else
        o_next = i_count + WIDTH'(1);
`endif
      end
      OP_DEC: begin
`ifdef UDS_COUNTER_SATURATE_EN
        if (w_is_zero) o_blocked = 1'b1;
        else           o_next    = i_count - WIDTH'(1);
`else
        o_next = i_count - WIDTH'(1);
`endif
      end
      default:  o_next = i_count;
    endcase
  end

`ifndef UDS_COUNTER_SATURATE_EN
  // End decodes only steer clamping; in the wrapping build they are idle.
  logic w_unused_ends;
  assign w_unused_ends = w_is_max ^ w_is_zero;
`endif

endmodule

// File: rtl/up_only_counter.sv
// Free-running delay counter: up_down_set_counter with down/set tied low.
// Pulsing clr restarts from 0; honours UDS_COUNTER_SATURATE_EN like the core.
module up_only_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH     = CNT_W_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic w_unused_at_zero;
  logic w_unused_at_max;
`ifdef UDS_COUNTER_SATURATE_EN
  logic w_unused_sat_hit;
`endif

  up_down_set_counter #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .up       (en),
    .down     (1'b0),
    .set      (1'b0),
    .clr      (clr),
    .load_val ({WIDTH{1'b0}}),
    .count    (count),
    .at_zero  (w_unused_at_zero),
    .at_max   (w_unused_at_max)
`ifdef UDS_COUNTER_SATURATE_EN
    ,
    .sat_hit  (w_unused_sat_hit)
`endif
  );

endmodule

// File: rtl/up_down_set_counter.sv
// Generic synchronous counter: clear, parallel load, increment, decrement.
// Build option UDS_COUNTER_SATURATE_EN clamps at the ends and adds sat_hit.
module up_down_set_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH     = CNT_W_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic             set,
  input  logic             clr,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_zero,
  output logic             at_max
`ifdef UDS_COUNTER_SATURATE_EN
  ,
  output logic             sat_hit
`endif
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  op_e              w_op;

  // rst is folded into the op-code so the datapath owns every priority.
  assign w_op = resolve_op(rst, clr, set, up, down);

`ifdef UDS_COUNTER_SATURATE_EN
  logic r_sat_hit;
  logic w_blocked;
`endif

  counter_next #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_next (
    .i_op       (w_op),
    .i_count    (r_count),
    .i_load_val (load_val),
    .o_next     (w_next)
`ifdef UDS_COUNTER_SATURATE_EN
    ,
    .o_blocked  (w_blocked)
`endif
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    r_count <= w_next;
  end

`ifdef UDS_COUNTER_SATURATE_EN
  always_ff @(posedge clk) begin
    if (rst) r_sat_hit <= 1'b0;
    else     r_sat_hit <= w_blocked;
  end
  assign sat_hit = r_sat_hit;
`endif

  assign count   = r_count;
  assign at_zero = (r_count == '0);
  assign at_max  = (r_count == {WIDTH{1'b1}});

endmodule

// File: tb/tb_up_down_set_counter.sv
// Scoreboard bench for up_down_set_counter (8 and 12 bit) and up_only_counter.
// Expectations follow UDS_COUNTER_SATURATE_EN when it is defined.
module tb_up_down_set_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared controls for the two core instances.
  logic        rst = 1'b0, clr = 1'b0, set = 1'b0, up = 1'b0, down = 1'b0;
  logic [7:0]  load8  = '0;
  logic [11:0] load12 = '0;
  logic [7:0]  count8;
  logic [11:0] count12;
  logic        zero8, max8, zero12, max12;
`ifdef UDS_COUNTER_SATURATE_EN
  logic        hit8, hit12;
`endif

  logic        rst_d = 1'b0, en_d = 1'b0, clr_d = 1'b0;
  logic [7:0]  count_d;

  up_down_set_counter #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
    .clk(clk), .rst(rst), .up(up), .down(down), .set(set), .clr(clr),
    .load_val(load8), .count(count8), .at_zero(zero8), .at_max(max8)
`ifdef UDS_COUNTER_SATURATE_EN
    , .sat_hit(hit8)
`endif
  );

  up_down_set_counter #(.WIDTH(12), .RESET_VAL(12'h000)) dut12 (
    .clk(clk), .rst(rst), .up(up), .down(down), .set(set), .clr(clr),
    .load_val(load12), .count(count12), .at_zero(zero12), .at_max(max12)
`ifdef UDS_COUNTER_SATURATE_EN
    , .sat_hit(hit12)
`endif
  );

  up_only_counter #(.WIDTH(8)) dut_delay (
    .clk(clk), .rst(rst_d), .en(en_d), .clr(clr_d), .count(count_d)
  );

  typedef struct {
    int          dut;   // 0: 8-bit core, 1: 12-bit core, 2: delay counter
    logic [11:0] cnt;
    logic        hit;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: each edge after a stimulus push, compare the targeted DUT.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        case (e.dut)
          0: begin
            check({e.nm, " count"},   32'(count8), 32'(e.cnt));
            check({e.nm, " at_zero"}, 32'(zero8),  32'(e.cnt == 12'h000));
            check({e.nm, " at_max"},  32'(max8),   32'(e.cnt == 12'h0FF));
`ifdef UDS_COUNTER_SATURATE_EN
            check({e.nm, " sat_hit"}, 32'(hit8),   32'(e.hit));
`endif
          end
          1: begin
            check({e.nm, " count"},   32'(count12), 32'(e.cnt));
            check({e.nm, " at_zero"}, 32'(zero12),  32'(e.cnt == 12'h000));
            check({e.nm, " at_max"},  32'(max12),   32'(e.cnt == 12'hFFF));
`ifdef UDS_COUNTER_SATURATE_EN
            check({e.nm, " sat_hit"}, 32'(hit12),   32'(e.hit));
`endif
          end
          default: check({e.nm, " count"}, 32'(count_d), 32'(e.cnt));
        endcase
      end
    end
  end

  // Drive one cycle of core stimulus and queue the expected post-edge state.
  task automatic apply(input int dut, input string nm,
                       input logic r, input logic c, input logic s,
                       input logic u, input logic d, input logic [11:0] lv,
                       input logic [11:0] exp_wrap, input logic [11:0] exp_sat,
                       input logic exp_hit);
    exp_t e;
    @(negedge clk);
    rst = r; clr = c; set = s; up = u; down = d;
    load8 = lv[7:0]; load12 = lv;
    e.dut = dut;
    e.nm  = nm;
`ifdef UDS_COUNTER_SATURATE_EN
    e.cnt = exp_sat;
    e.hit = exp_hit;
`else
    e.cnt = exp_wrap;
    e.hit = 1'b0;
    if (exp_sat == 12'hFFF && exp_hit) e.hit = 1'b0;
`endif
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t        e;
    logic [11:0] exp_d;
    int          wait_cyc;

    //      dut name           rst clr set up dn  load    wrap    sat     hit
    apply(0, "rst_with_up",    1, 0, 0, 1, 0, 12'h0AA, 12'h00, 12'h00, 0);
    apply(0, "load_37",        0, 0, 1, 0, 0, 12'h037, 12'h37, 12'h37, 0);
    apply(0, "rst_over_count", 1, 0, 0, 1, 0, 12'h000, 12'h00, 12'h00, 0);
    apply(0, "load_fe",        0, 0, 1, 0, 0, 12'h0FE, 12'hFE, 12'hFE, 0);
    apply(0, "inc_to_ff",      0, 0, 0, 1, 0, 12'h000, 12'hFF, 12'hFF, 0);
    apply(0, "inc_wrap",       0, 0, 0, 1, 0, 12'h000, 12'h00, 12'hFF, 1);
    apply(0, "inc_after_wrap", 0, 0, 0, 1, 0, 12'h000, 12'h01, 12'hFF, 1);
    apply(0, "load_01",        0, 0, 1, 0, 0, 12'h001, 12'h01, 12'h01, 0);
    apply(0, "dec_to_0",       0, 0, 0, 0, 1, 12'h000, 12'h00, 12'h00, 0);
    apply(0, "dec_wrap",       0, 0, 0, 0, 1, 12'h000, 12'hFF, 12'h00, 1);
    apply(0, "load_10",        0, 0, 1, 0, 0, 12'h010, 12'h10, 12'h10, 0);
    apply(0, "up_down_hold",   0, 0, 0, 1, 1, 12'h0AA, 12'h10, 12'h10, 0);
    apply(0, "set_beats_up",   0, 0, 1, 1, 0, 12'h005, 12'h05, 12'h05, 0);
    apply(0, "clr_beats_set",  0, 1, 1, 0, 0, 12'h005, 12'h00, 12'h00, 0);
    apply(0, "idle_ignore_lv", 0, 0, 0, 0, 0, 12'h0AA, 12'h00, 12'h00, 0);
    apply(0, "clr_beats_dec",  0, 1, 0, 0, 1, 12'h000, 12'h00, 12'h00, 0);

    apply(1, "w12_rst",        1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0);
    apply(1, "w12_load_0",     0, 0, 1, 0, 0, 12'h000, 12'h000, 12'h000, 0);
    for (int i = 1; i <= 7; i++) begin
      apply(1, $sformatf("w12_up%0d", i),   0, 0, 0, 1, 0, 12'h000,
            12'(i), 12'(i), 0);
      apply(1, $sformatf("w12_idle%0d", i), 0, 0, 0, 0, 0, 12'h123,
            12'(i), 12'(i), 0);
    end
    apply(1, "w12_load_fff",   0, 0, 1, 0, 0, 12'hFFF, 12'hFFF, 12'hFFF, 0);
    apply(1, "w12_inc_wrap",   0, 0, 0, 1, 0, 12'h000, 12'h000, 12'hFFF, 1);
    apply(1, "w12_idle_end",   0, 0, 0, 0, 0, 12'h000, 12'h000, 12'hFFF, 0);

    // Delay counter: restart on clr whenever the caller sees count == 15.
    @(negedge clk);
    rst = 1'b0; clr = 1'b0; set = 1'b0; up = 1'b0; down = 1'b0;
    rst_d = 1'b1; en_d = 1'b1; clr_d = 1'b0;
    e.dut = 2; e.cnt = 12'h000; e.hit = 1'b0; e.nm = "delay_rst";
    exp_q.push_back(e);
    exp_d = 12'h000;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      rst_d = 1'b0;
      clr_d = (count_d == 8'd15);
      exp_d = (exp_d == 12'd15) ? 12'h000 : exp_d + 12'd1;
      e.dut = 2; e.cnt = exp_d; e.hit = 1'b0;
      e.nm  = $sformatf("delay_c%0d", i);
      exp_q.push_back(e);
    end
    @(negedge clk);
    clr_d = 1'b0; en_d = 1'b0;

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
